// File: rtl/apb_mem_completer_if.sv
// APB bus bundle between a requester (master) and apb_mem_completer (slave).
interface apb_mem_completer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_mem_completer.sv
// APB completer backed by a word-addressed register array.
// Decodes PADDR against a base window, flags misaligned/out-of-window
// accesses with PSLVERR, and completes with a registered PREADY.
// Optional fixed wait states: define APB_MEMC_WAIT_EN to build the WAIT
// state and counter (WAIT_CYCLES per transfer); otherwise every transfer
// is setup + one access cycle.
module apb_mem_completer #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_CYCLES = 2
) (
  input logic                PCLK,
  input logic                PRESET,
  apb_mem_completer_if.slave apb
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef APB_MEMC_WAIT_EN
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [0:0] {S_IDLE, S_RESP} state_e;
  // Wait states are not built; the parameter stays for drop-in compatibility.
  localparam int unsigned WAIT_CYCLES_UNUSED = WAIT_CYCLES;
`endif

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  commit;

  logic [ADDR_WIDTH-1:0] dec_off;
  logic                  dec_err;
  logic [IDX_W-1:0]      dec_idx;
  logic [DATA_WIDTH-1:0] dec_rdata;

  // Address decode: full-width offset so addresses past the window never wrap.
  always_comb begin
    dec_off   = apb.PADDR - BASE_ADDR;
    dec_err   = (apb.PADDR[1:0] != 2'b00) ||
                (apb.PADDR < BASE_ADDR) ||
                ((dec_off >> 2) >= ADDR_WIDTH'(DEPTH));
    dec_idx   = dec_off[IDX_W+1:2];
    dec_rdata = (!apb.PWRITE && !dec_err) ? mem_q[dec_idx] : '0;
  end

  // Next-state and next-output logic; outputs are only non-zero entering RESP.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    commit    = 1'b0;
`ifdef APB_MEMC_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (apb.PSELx && !apb.PENABLE) begin
          idx_d   = dec_idx;
          write_d = apb.PWRITE;
          wdata_d = apb.PWDATA;
          err_d   = dec_err;
          rdata_d = dec_rdata;
`ifdef APB_MEMC_WAIT_EN
          if (WAIT_CYCLES != 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end else begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = dec_err;
            prdata_d  = dec_rdata;
          end
`else
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = dec_err;
          prdata_d  = dec_rdata;
`endif
        end
      end
`ifdef APB_MEMC_WAIT_EN
      S_WAIT: begin
        if (!apb.PSELx) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = rdata_q;
          end
        end
      end
`endif
      S_RESP: begin
        state_d = S_IDLE;
        commit  = apb.PSELx && write_q && !err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched transfer, registered outputs and array storage.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      mem_q     <= '{default: '0};
`ifdef APB_MEMC_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
`ifdef APB_MEMC_WAIT_EN
      cnt_q     <= cnt_d;
`endif
      if (commit) begin
        mem_q[idx_q] <= wdata_q;
      end
    end
  end

  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;
  assign apb.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Directed bench for apb_mem_completer (BASE_ADDR=0x1000, DEPTH=256).
// Wait-state expectations follow APB_MEMC_WAIT_EN (WAIT_CYCLES=3 when defined).
module tb_apb_mem_completer;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef APB_MEMC_WAIT_EN
  localparam int EW = 3;
`else
  localparam int EW = 0;
`endif

  logic PCLK;
  logic PRESET;
  int   errors;
  int   checks;

  apb_mem_completer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_mem_completer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (256),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(3)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .apb   (bus)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transfer; entered and left at 1 time unit after a rising edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int acc);
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wd;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    acc = 0;
    rd  = '0;
    er  = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge PCLK);
      if (bus.PREADY) begin
        acc = k;
        rd  = bus.PRDATA;
        er  = bus.PSLVERR;
        break;
      end
    end
    @(posedge PCLK); #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          acc;
    xfer(1'b1, addr, wd, rd, er, acc);
    check({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, ".cycles"}, acc, EW + 1);
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          acc;
    xfer(1'b0, addr, '0, rd, er, acc);
    check({tag, ".data"}, rd, exp_data);
    check({tag, ".err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, ".cycles"}, acc, EW + 1);
  endtask

  task automatic idle(input int n);
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (n) begin
      @(posedge PCLK); #1;
    end
  endtask

  initial begin
    int got_ready;
    errors      = 0;
    checks      = 0;
    PRESET      = 1'b1;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;

    #12;
    check("reset.pready", {31'd0, bus.PREADY}, 32'd0);
    check("reset.pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    check("reset.prdata", bus.PRDATA, 32'd0);
    #9 PRESET = 1'b0;
    @(posedge PCLK); #1;

    do_write("wr_beef", BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
    do_read ("rd_beef", BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
    idle(1);

    do_write("wr_oor", BASE + 32'h400, 32'h1234_5678, 1'b1);
    do_read ("rd_w0_after_oor", BASE, 32'h0, 1'b0);
    do_write("wr_last", BASE + 32'h3FC, 32'hA5A5_0001, 1'b0);
    do_read ("rd_last", BASE + 32'h3FC, 32'hA5A5_0001, 1'b0);
    do_read ("rd_below_base", BASE - 32'h4, 32'h0, 1'b1);
    idle(2);

    for (int i = 0; i < 4; i++)
      do_write($sformatf("b2b_wr%0d", i), BASE + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 1'b0);
    for (int i = 0; i < 4; i++)
      do_read($sformatf("b2b_rd%0d", i), BASE + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 1'b0);
    do_read ("rd_misaligned", BASE + 32'h2, 32'h0, 1'b1);
    do_read ("rd_beef_again", BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
    idle(1);

    // Abort: drop PSELx right after the setup edge of a write to word 5.
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b1;
    bus.PADDR   = BASE + 32'h14;
    bus.PWDATA  = 32'hCAFE_F00D;
    @(posedge PCLK); #1;
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    @(negedge PCLK);
    check("abort.pready_first", {31'd0, bus.PREADY}, (EW == 0) ? 32'd1 : 32'd0);
    @(negedge PCLK);
    check("abort.pready_after", {31'd0, bus.PREADY}, 32'd0);
    @(posedge PCLK); #1;
    do_read("abort.rd_w5", BASE + 32'h14, 32'h0, 1'b0);

    // Reset asserted while a read of word 4 is presenting its response.
    bus.PSELx   = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = BASE + 32'h10;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    got_ready = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge PCLK);
      if (bus.PREADY) begin
        got_ready = k;
        break;
      end
    end
    check("rst_mid.cycles", got_ready, EW + 1);
    check("rst_mid.prdata_before", bus.PRDATA, 32'hDEAD_BEEF);
    PRESET = 1'b1;
    #1;
    check("rst_mid.pready", {31'd0, bus.PREADY}, 32'd0);
    check("rst_mid.pslverr", {31'd0, bus.PSLVERR}, 32'd0);
    check("rst_mid.prdata", bus.PRDATA, 32'd0);
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    idle(1);
    do_read("rst_mid.rd_w4", BASE + 32'h10, 32'h0, 1'b0);
    do_read("rst_mid.rd_w1", BASE + 32'h4, 32'h0, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_mem_completer.md
# apb_mem_completer

APB completer (slave) that terminates transfers issued by the team's APB requester/driver and backs them with a word-addressed register array. It decodes PADDR against a base window, performs writes and reads, and signals completion with PREADY. It flags bad accesses with PSLVERR. With wait states compiled in, it inserts a fixed number of wait cycles before completing each transfer.

## Interface
- ADDR_WIDTH, 32, width of PADDR
- DATA_WIDTH, 32, width of PWDATA/PRDATA
- DEPTH, 256, number of DATA_WIDTH-bit words in the array
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- WAIT_CYCLES, 2, wait cycles per transfer; used only with APB_MEMC_WAIT_EN

Ports:
- PCLK  input  1  clock; all state changes on rising edge
- PRESET  input  1  reset; asynchronous and active-high
- PSELx  input  1  completer select
- PENABLE  input  1  access-phase indicator
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  ADDR_WIDTH  byte address
- PWDATA  input  DATA_WIDTH  write data
- PRDATA  output  DATA_WIDTH  read data; valid only while PREADY=1
- PREADY  output  1  transfer completes at the rising edge where PSELx&PENABLE&PREADY
- PSLVERR  output  1  error response; valid only while PREADY=1

## Operation
- FSM has three states: IDLE, WAIT, RESP. All outputs are registered.
- **Reset** (PRESET=1, asynchronous):
  - State goes to IDLE.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - All array words are set to 0.
  - Wait counter is set to 0.
- **IDLE:**
  - A setup cycle (PSELx=1, PENABLE=0) sampled at an edge latches PADDR, PWRITE and PWDATA.
  - At the same edge, it evaluates the error condition and captures the read word.
  - If the effective wait count is 0, the FSM moves to RESP. Otherwise it moves to WAIT with the counter set to WAIT_CYCLES.
- **Error condition** (any of the following):
  - PADDR[1:0] != 0.
  - PADDR < BASE_ADDR.
  - (PADDR-BASE_ADDR)>>2 >= DEPTH.
  - The index is computed at full ADDR_WIDTH with no wrap-around.
- **WAIT:**
  - PREADY=0.
  - The counter decrements each edge. At the edge where the counter equals 1, the FSM moves to RESP.
- **RESP:**
  - PREADY=1 for exactly one cycle.
  - PSLVERR=error flag.
  - PRDATA = stored word for an error-free read, otherwise 0.
  - At the completing edge, an error-free write commits the latched PWDATA to the array. The FSM then returns to IDLE.
- Error transfers never modify the array.
- **Abort:** if PSELx=0 is sampled in WAIT or RESP, the FSM returns to IDLE. No write is committed, and the outputs return to their idle values.
- **Outputs outside RESP:** PREADY=0, PSLVERR=0, PRDATA=0.

## Timing
- **Zero-wait transfer:** 2 cycles (setup + access). PREADY rises after the setup edge and is high throughout the first access cycle.
- **With waits:** the access phase lasts WAIT_CYCLES+1 cycles. PREADY is high only in the last of them.
- **Back-to-back:** a new setup cycle may immediately follow the completing access cycle, with no idle cycle required.
- **Read after write to the same word:** the write commits at the completing edge. The next read's setup edge is strictly later, so it returns the new data.
- **Mid-transfer reset:** the transfer is discarded. Outputs go to reset values immediately, without waiting for PCLK.
- The block does not check the PENABLE/PSELx sequence beyond the abort rule. PENABLE is not sampled in IDLE except to qualify setup.

## Configuration
- **Macro:** APB_MEMC_WAIT_EN.
- **Defined:**
  - The WAIT state and counter are compiled in.
  - The effective wait count is WAIT_CYCLES.
  - WAIT_CYCLES=0 behaves as zero-wait.
- **Undefined:**
  - No WAIT state and no counter are built.
  - The effective wait count is always 0, so every transfer is 2 cycles.
  - The WAIT_CYCLES parameter is ignored.

## Test plan
- **Write then read:** write 32'hDEAD_BEEF to BASE_ADDR+0x10, then read the same address.
  - Read returns 32'hDEAD_BEEF with PSLVERR=0.
  - Without APB_MEMC_WAIT_EN, each transfer takes 2 cycles.
- **Out-of-range write:** write to BASE_ADDR+4*DEPTH (e.g. 0x400 with DEPTH=256).
  - PSLVERR=1 in the completing cycle.
  - A follow-up read of word 0 still returns 0.
- **Misaligned read:** read at BASE_ADDR+0x2.
  - PSLVERR=1 and PRDATA=0.
- **Wait states** (APB_MEMC_WAIT_EN, WAIT_CYCLES=3):
  - PREADY=0 for 3 access cycles, then high for 1.
  - Access phase is 4 cycles, transfer is 5 cycles.
- **Back-to-back writes:** writes to words 0..3 with no idle cycles.
  - All complete.
  - Readback returns the written values.
- **Abort and reset mid-transfer:**
  - Drop PSELx during WAIT: the write is not committed, and PREADY stays 0.
  - Assert PRESET during RESP: PREADY, PSLVERR and PRDATA go to 0 asynchronously, and the array reads 0 afterward.
